bit_tx_sequencer: RTL and testbench

//  Clocked sequencer driving the one/zero bit-signalling cells of the serial link.

---
 rtl/bit_tx_sequencer_pkg.sv | 14 +
 rtl/bit_tx_sequencer_sync2.sv | 23 ++
 rtl/bit_tx_sequencer.sv | 153 +++++++++++++++
 tb/tb_bit_tx_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_tx_sequencer_pkg.sv
// Shared types and constants for the bit transmit sequencer.
package bit_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_REL     = 3'd2,
    ST_END_REQ = 3'd3,
    ST_END_REL = 3'd4
  } state_e;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/bit_tx_sequencer_sync2.sv
// Flop-chain synchroniser for an asynchronous acknowledge; clears to 0 on reset.
module sync2
  import bit_tx_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_DEPTH-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_DEPTH-2:0], async_i};
    end
  end

  assign sync_o = chain_q[SYNC_DEPTH-1];

endmodule

// File: rtl/bit_tx_sequencer.sv
// Sends a word LSB first as 4-phase one/zero requests, then an end-of-word handshake.
//  state   | meaning
//  IDLE    | ready, waiting for load
//  REQ     | one_req or zero_req high for sr[0], waiting for ack_s=1
//  REL     | requests low, waiting for ack_s=0
//  END_REQ | end_req high, waiting for sen_s=1
//  END_REL | end_req low, waiting for sen_s=0, then done
module bit_tx_sequencer
  import bit_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TMO_MAX = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             one_req_o,
  output logic             zero_req_o,
  input  logic             bit_ack_i,
  output logic             end_req_o,
  input  logic             sen_ack_i,
  output logic             done_o,
  output logic             tmo_err_o
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned TW = $clog2(TMO_MAX);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TMO_MAX - 1);

  logic ack_s;
  logic sen_s;

  sync2 u_sync_bit_ack (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (bit_ack_i),
    .sync_o  (ack_s)
  );

  sync2 u_sync_sen_ack (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (sen_ack_i),
    .sync_o  (sen_s)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             ready_q, ready_d;
  logic             one_req_q, one_req_d;
  logic             zero_req_q, zero_req_d;
  logic             end_req_q, end_req_d;
  logic             done_q, done_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tmo_hit;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    idx_d     = idx_q;
    tmo_err_d = tmo_err_q;
    done_d    = 1'b0;
    // The wait timer is a down-counter; terminal count in any wait state aborts the word.
    tmo_hit   = (state_q != ST_IDLE) && (tmr_q == '0);

    if (tmo_hit) begin
      state_d   = ST_IDLE;
      tmo_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            sr_d      = data_i;
            idx_d     = '0;
            tmo_err_d = 1'b0;
            state_d   = ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s) state_d = ST_REL;
        end
        ST_REL: begin
          if (!ack_s) begin
            sr_d = sr_q >> 1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_END_REQ;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = ST_REQ;
            end
          end
        end
        ST_END_REQ: begin
          if (sen_s) state_d = ST_END_REL;
        end
        ST_END_REL: begin
          if (!sen_s) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    tmr_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? TMR_LOAD : tmr_q - TW'(1);

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    ready_d    = (state_d == ST_IDLE);
    one_req_d  = (state_d == ST_REQ) && sr_d[0];
    zero_req_d = (state_d == ST_REQ) && !sr_d[0];
    end_req_d  = (state_d == ST_END_REQ);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      idx_q      <= '0;
      tmr_q      <= TMR_LOAD;
      ready_q    <= 1'b1;
      one_req_q  <= 1'b0;
      zero_req_q <= 1'b0;
      end_req_q  <= 1'b0;
      done_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      ready_q    <= ready_d;
      one_req_q  <= one_req_d;
      zero_req_q <= zero_req_d;
      end_req_q  <= end_req_d;
      done_q     <= done_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign ready_o    = ready_q;
  assign one_req_o  = one_req_q;
  assign zero_req_o = zero_req_q;
  assign end_req_o  = end_req_q;
  assign done_o     = done_q;
  assign tmo_err_o  = tmo_err_q;

endmodule

// File: tb/tb_bit_tx_sequencer.sv
// Bench for bit_tx_sequencer: cell/receiver models, protocol monitor, vector table, corner cases.
module tb_bit_tx_sequencer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] data;
  logic       ready;
  logic       one_req;
  logic       zero_req;
  logic       bit_ack;
  logic       end_req;
  logic       sen_ack;
  logic       done;
  logic       tmo_err;

  bit_tx_sequencer #(.WIDTH(8), .TMO_MAX(16)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load),
    .data_i     (data),
    .ready_o    (ready),
    .one_req_o  (one_req),
    .zero_req_o (zero_req),
    .bit_ack_i  (bit_ack),
    .end_req_o  (end_req),
    .sen_ack_i  (sen_ack),
    .done_o     (done),
    .tmo_err_o  (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Cell / receiver model controls
  int fix_dly   = 0;
  bit rnd       = 1'b0;
  int stall_bit = -1;

  // Monitor state
  int         cyc = 0;
  logic [1:0] hist = 2'b00;
  logic       p_one = 1'b0, p_zero = 1'b0, p_end = 1'b0, p_tmo = 1'b0;
  int         cur_n = 0;
  logic [7:0] cur_bits = 8'h00;
  int         rise_cyc[$];
  int         end_cyc = 0;
  int         done_cyc = 0;
  int         tmo_cyc = 0;
  int         done_cnt = 0;
  logic [7:0] word_q[$];
  int         nbits_q[$];

  // Bit cell and receiver: follow their request after a programmable number of cycles.
  initial begin
    int  b_cnt, s_cnt, b_rdly, s_rdly;
    bit  tgt;
    b_cnt = 0; s_cnt = 0; b_rdly = 0; s_rdly = 0;
    bit_ack = 1'b0;
    sen_ack = 1'b0;
    forever begin
      @(negedge clk);
      tgt = (one_req | zero_req) && !(stall_bit >= 0 && cur_n - 1 == stall_bit);
      if (bit_ack != tgt) begin
        if (b_cnt >= (rnd ? b_rdly : fix_dly)) begin
          bit_ack = tgt; b_cnt = 0; b_rdly = $urandom_range(0, 10);
        end else b_cnt++;
      end else b_cnt = 0;
      if (sen_ack != end_req) begin
        if (s_cnt >= (rnd ? s_rdly : fix_dly)) begin
          sen_ack = end_req; s_cnt = 0; s_rdly = $urandom_range(0, 10);
        end else s_cnt++;
      end else s_cnt = 0;
    end
  end

  // Protocol monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      hist = {hist[0], bit_ack};
      #1;
      if ((one_req && !p_one) || (zero_req && !p_zero)) begin
        chk("mon_exclusive", one_req && zero_req, 0);
        chk("mon_rise_while_ack_s", hist[1], 0);
        if (cur_n < 8) cur_bits[cur_n] = one_req;
        cur_n++;
        rise_cyc.push_back(cyc);
      end
      if (end_req && !p_end) end_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        word_q.push_back(cur_bits);
        nbits_q.push_back(cur_n);
        cur_n = 0; cur_bits = 8'h00;
      end
      if (tmo_err && !p_tmo) begin
        tmo_cyc = cyc;
        cur_n = 0; cur_bits = 8'h00;
      end
      p_one = one_req; p_zero = zero_req; p_end = end_req; p_tmo = tmo_err;
    end
  end

  task automatic send_word(input logic [7:0] d, input int dly, output int acc);
    fix_dly = dly;
    rise_cyc.delete();
    @(negedge clk);
    data = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    acc  = cyc;
    load = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt - base, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         dly;
    int         ones;
    int         period;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int acc, base, n;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 0, 4, 6};
    vecs[1] = '{8'h00, 0, 0, 6};
    vecs[2] = '{8'hFF, 1, 8, 8};
    vecs[3] = '{8'h3C, 2, 4, 10};
    vecs[4] = '{8'h81, 3, 2, 12};

    // 1. reset with both acks low
    reset = 1'b1; load = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_one_req", one_req, 0);
    chk("rst_zero_req", zero_req, 0);
    chk("rst_end_req", end_req, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo_err", tmo_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2. vector table, including 8'hA5 with an immediate cell
    for (int i = 0; i < 5; i++) begin
      base = done_cnt;
      send_word(vecs[i].data, vecs[i].dly, acc);
      chk("vec_ready_low", ready, 0);
      wait_done(base, 400, "vec_done");
      repeat (3) @(negedge clk);
      chk("vec_done_once", done_cnt - base, 1);
      chk("vec_word", word_q[$], vecs[i].data);
      chk("vec_nbits", nbits_q[$], 8);
      chk("vec_ones", $countones(word_q[$]), vecs[i].ones);
      chk("vec_first_req", rise_cyc[0], acc);
      if (rise_cyc.size() >= 8) begin
        for (int k = 1; k < 8; k++)
          chk("vec_bit_period", rise_cyc[k] - rise_cyc[k-1], vecs[i].period);
        chk("vec_end_gap", end_cyc - rise_cyc[7], vecs[i].period);
      end
      chk("vec_word_time", done_cyc - acc, 9 * vecs[i].period);
      chk("vec_ready_back", ready, 1);
      chk("vec_tmo_clear", tmo_err, 0);
    end

    // 3. stalled cell on bit 3 -> timeout 16 cycles after REQ entry
    base = done_cnt;
    stall_bit = 3;
    send_word(8'hA5, 0, acc);
    n = 0;
    while (!tmo_err && n < 100) begin @(negedge clk); n++; end
    chk("tmo_flag", tmo_err, 1);
    if (rise_cyc.size() >= 4) chk("tmo_latency", tmo_cyc - rise_cyc[3], 16);
    chk("tmo_one_req", one_req, 0);
    chk("tmo_zero_req", zero_req, 0);
    chk("tmo_ready", ready, 1);
    repeat (3) @(negedge clk);
    chk("tmo_no_done", done_cnt - base, 0);
    chk("tmo_sticky", tmo_err, 1);
    stall_bit = -1;
    base = done_cnt;
    send_word(8'h5A, 0, acc);
    chk("tmo_cleared_on_accept", tmo_err, 0);
    wait_done(base, 400, "tmo_recover_done");
    chk("tmo_recover_word", word_q[$], 8'h5A);
    chk("tmo_recover_nbits", nbits_q[$], 8);

    // 4. load during a transfer is ignored
    base = done_cnt;
    send_word(8'h96, 0, acc);
    repeat (10) @(negedge clk);
    data = 8'h11; load = 1'b1;
    @(negedge clk);
    load = 1'b0; data = 8'h00;
    wait_done(base, 400, "ign_done");
    chk("ign_word", word_q[$], 8'h96);
    repeat (12) @(negedge clk);
    chk("ign_no_new_req", cur_n, 0);
    chk("ign_done_once", done_cnt - base, 1);
    chk("ign_ready", ready, 1);

    // 4b. load held across completion: accepted the cycle after done
    base = done_cnt;
    send_word(8'hC3, 0, acc);
    repeat (20) @(negedge clk);
    data = 8'h0F; load = 1'b1;
    wait_done(base, 400, "coin_done");
    n = 0;
    while (cur_n < 1 && n < 20) begin @(negedge clk); n++; end
    load = 1'b0;
    chk("coin_word", word_q[$], 8'hC3);
    chk("coin_accept_delay", rise_cyc[$] - done_cyc, 1);
    base = done_cnt;
    wait_done(base, 400, "coin_second_done");
    chk("coin_second_word", word_q[$], 8'h0F);

    // 5. reset asserted while in REQ for bit 5
    send_word(8'hA5, 0, acc);
    n = 0;
    while (cur_n < 6 && n < 100) begin @(negedge clk); n++; end
    chk("midrst_reached_bit5", cur_n, 6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_one_req", one_req, 0);
    chk("midrst_zero_req", zero_req, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_idx", dut.idx_q, 0);
    @(negedge clk);
    reset = 1'b0;
    cur_n = 0; cur_bits = 8'h00;
    repeat (6) @(negedge clk);
    base = done_cnt;
    send_word(8'hFF, 0, acc);
    wait_done(base, 400, "midrst_done");
    chk("midrst_word", word_q[$], 8'hFF);
    chk("midrst_nbits", nbits_q[$], 8);

    // 6. random words with random ack delays
    rnd = 1'b1;
    for (int w = 0; w < 20; w++) begin
      d = 8'($urandom_range(0, 255));
      base = done_cnt;
      send_word(d, 0, acc);
      wait_done(base, 600, "rnd_done");
      chk("rnd_word", word_q[$], d);
      chk("rnd_nbits", nbits_q[$], 8);
      chk("rnd_tmo", tmo_err, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rnd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
